// File: rtl/rsa_job_arbiter.sv
// Two-port job arbiter for a shared RSA modexp core: round-robin accept, operand
// latching, core reset/start sequencing, timeout watchdog and per-port result return.
module rsa_job_arbiter #(
    parameter int WIDTH          = 32,
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             resetn,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_m,
    input  logic [WIDTH-1:0] req0_e,
    input  logic [WIDTH-1:0] req0_n,
    input  logic [WIDTH-1:0] req0_ninv,
    input  logic [WIDTH-1:0] req0_r2,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_m,
    input  logic [WIDTH-1:0] req1_e,
    input  logic [WIDTH-1:0] req1_n,
    input  logic [WIDTH-1:0] req1_ninv,
    input  logic [WIDTH-1:0] req1_r2,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_c,
    output logic             rsp0_err,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_c,
    output logic             rsp1_err,

    output logic             core_rst,
    output logic             core_start,
    output logic [WIDTH-1:0] core_m,
    output logic [WIDTH-1:0] core_e,
    output logic [WIDTH-1:0] core_n,
    output logic [WIDTH-1:0] core_ninv,
    output logic [WIDTH-1:0] core_r2,
    input  logic [WIDTH-1:0] core_c,
    input  logic             core_done,

    output logic             busy,
    output logic             owner,
    output logic [7:0]       timeout_count
);

    localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] RST_LOAD   = CW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN, S_RESP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] m_q, m_d, e_q, e_d, n_q, n_d, ninv_q, ninv_d, r2_q, r2_d;
    logic [WIDTH-1:0] c0_q, c0_d, c1_q, c1_d;
    logic             err0_q, err0_d, err1_q, err1_d;
    logic             vld0_q, vld0_d, vld1_q, vld1_d;
    logic [7:0]       tocnt_q, tocnt_d;

    logic grant, handshake, done_ok, timed_out, rsp_sel_valid, rsp_sel_ready;

    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) grant = ~last_grant_q;
        else if (req1_valid)          grant = 1'b1;
    end

    assign handshake  = (state_q == S_IDLE) && (req0_valid || req1_valid);
    assign req0_ready = (state_q == S_IDLE) && req0_valid && !grant;
    assign req1_ready = (state_q == S_IDLE) && req1_valid && grant;

    // Timer is zero only in the first RUN cycle, when core_done still reflects the previous job.
    assign done_ok       = core_done && (timer_q != '0);
    assign timed_out     = !done_ok && (timer_q == TIMER_LAST);
    assign rsp_sel_valid = owner_q ? vld1_q : vld0_q;
    assign rsp_sel_ready = owner_q ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (handshake) state_d = S_RST;
            S_RST:  if (cnt_q == '0) state_d = S_RUN;
            S_RUN:  if (done_ok || timed_out) state_d = S_RESP;
            S_RESP: if (rsp_sel_valid && rsp_sel_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        core_rst   = (state_q != S_RUN);
        core_start = (state_q == S_RUN);
        busy       = (state_q != S_IDLE);
    end

    always_comb begin
        cnt_d        = cnt_q;
        timer_d      = timer_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        m_d = m_q; e_d = e_q; n_d = n_q; ninv_d = ninv_q; r2_d = r2_q;
        c0_d = c0_q; c1_d = c1_q;
        err0_d = err0_q; err1_d = err1_q;
        vld0_d = vld0_q; vld1_d = vld1_q;
        tocnt_d = tocnt_q;
        case (state_q)
            S_IDLE: if (handshake) begin
                m_d          = grant ? req1_m    : req0_m;
                e_d          = grant ? req1_e    : req0_e;
                n_d          = grant ? req1_n    : req0_n;
                ninv_d       = grant ? req1_ninv : req0_ninv;
                r2_d         = grant ? req1_r2   : req0_r2;
                owner_d      = grant;
                last_grant_d = grant;
                cnt_d        = RST_LOAD;
            end
            S_RST: begin
                timer_d = '0;
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            end
            S_RUN: begin
                timer_d = timer_q + 1'b1;
                if (done_ok || timed_out) begin
                    if (owner_q) begin
                        c1_d = done_ok ? core_c : '0;  err1_d = timed_out;  vld1_d = 1'b1;
                    end else begin
                        c0_d = done_ok ? core_c : '0;  err0_d = timed_out;  vld0_d = 1'b1;
                    end
                    if (timed_out && tocnt_q != 8'hFF) tocnt_d = tocnt_q + 8'd1;
                end
            end
            S_RESP: if (rsp_sel_valid && rsp_sel_ready) begin
                if (owner_q) vld1_d = 1'b0;
                else         vld0_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;  timer_q <= '0;
            last_grant_q <= 1'b1;  owner_q <= 1'b0;
            m_q <= '0;  e_q <= '0;  n_q <= '0;  ninv_q <= '0;  r2_q <= '0;
            c0_q <= '0;  c1_q <= '0;
            err0_q <= 1'b0;  err1_q <= 1'b0;
            vld0_q <= 1'b0;  vld1_q <= 1'b0;
            tocnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;  timer_q <= timer_d;
            last_grant_q <= last_grant_d;  owner_q <= owner_d;
            m_q <= m_d;  e_q <= e_d;  n_q <= n_d;  ninv_q <= ninv_d;  r2_q <= r2_d;
            c0_q <= c0_d;  c1_q <= c1_d;
            err0_q <= err0_d;  err1_q <= err1_d;
            vld0_q <= vld0_d;  vld1_q <= vld1_d;
            tocnt_q <= tocnt_d;
        end
    end

    assign core_m        = m_q;
    assign core_e        = e_q;
    assign core_n        = n_q;
    assign core_ninv     = ninv_q;
    assign core_r2       = r2_q;
    assign rsp0_valid    = vld0_q;
    assign rsp1_valid    = vld1_q;
    assign rsp0_c        = c0_q;
    assign rsp1_c        = c1_q;
    assign rsp0_err      = err0_q;
    assign rsp1_err      = err1_q;
    assign owner         = owner_q;
    assign timeout_count = tocnt_q;

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Directed bench for rsa_job_arbiter with a small latency-programmable core model.
module tb_rsa_job_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_m = '0, req0_e = '0, req0_n = '0, req0_ninv = '0, req0_r2 = '0;
    logic [W-1:0] req1_m = '0, req1_e = '0, req1_n = '0, req1_ninv = '0, req1_r2 = '0;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [W-1:0] rsp0_c, rsp1_c;
    logic         rsp0_err, rsp1_err;
    logic         core_rst, core_start, core_done;
    logic [W-1:0] core_m, core_e, core_n, core_ninv, core_r2;
    logic [W-1:0] core_c = '0;
    logic         busy, owner;
    logic [7:0]   timeout_count;

    int vectors = 0;
    int miscompares = 0;

    // Core model: done pulses in the lat-th cycle of core_start after a core reset.
    int run_cnt = 0;
    int lat = 10;
    bit model_en = 1'b1;
    bit done_force = 1'b0;

    always @(posedge clk) begin
        if (core_rst)        run_cnt <= 0;
        else if (core_start) run_cnt <= run_cnt + 1;
    end
    assign core_done = done_force || (model_en && core_start && (run_cnt == lat - 1));

    always #5 clk = ~clk;

    rsa_job_arbiter #(.WIDTH(W), .RST_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .resetn(resetn),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_m(req0_m), .req0_e(req0_e), .req0_n(req0_n), .req0_ninv(req0_ninv), .req0_r2(req0_r2),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_m(req1_m), .req1_e(req1_e), .req1_n(req1_n), .req1_ninv(req1_ninv), .req1_r2(req1_r2),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_c(rsp0_c), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_c(rsp1_c), .rsp1_err(rsp1_err),
        .core_rst(core_rst), .core_start(core_start),
        .core_m(core_m), .core_e(core_e), .core_n(core_n), .core_ninv(core_ninv), .core_r2(core_r2),
        .core_c(core_c), .core_done(core_done),
        .busy(busy), .owner(owner), .timeout_count(timeout_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input bit port, input string tag, output int n);
        n = 0;
        while (((port ? rsp1_valid : rsp0_valid) !== 1'b1) && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 64'((port ? rsp1_valid : rsp0_valid) === 1'b1), 64'd1);
    endtask

    initial begin
        int n, rst_n, st_n;
        bit bad;

        // Reset values
        #2;
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_core_rst", core_rst, 1);
        chk("rst_core_start", core_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_timeout_count", timeout_count, 0);
        chk("rst_core_m", core_m, 0);
        chk("rst_rsp0_c", rsp0_c, 0);
        chk("rst_rsp0_err", rsp0_err, 0);
        tick();
        tick();
        resetn = 1'b1;

        // Single job on port 0
        lat = 10; core_c = 26;
        req0_valid = 1'b1; req0_m = 5; req0_e = 3; req0_n = 33; req0_ninv = 32'h1234; req0_r2 = 32'h9;
        #1;
        chk("t1_req0_ready", req0_ready, 1);
        chk("t1_req1_ready", req1_ready, 0);
        tick();
        req0_valid = 1'b0; req0_m = 99; req0_e = 98;
        chk("t1_core_m", core_m, 5);
        chk("t1_core_e", core_e, 3);
        chk("t1_core_n", core_n, 33);
        chk("t1_core_ninv", core_ninv, 32'h1234);
        chk("t1_busy", busy, 1);
        chk("t1_req0_ready_busy", req0_ready, 0);
        n = 0; rst_n = 0; st_n = 0; bad = 0;
        while (!rsp0_valid && n < 100) begin
            if (core_start) st_n++;
            else if (core_rst) rst_n++;
            if (rsp1_valid) bad = 1;
            tick();
            n++;
        end
        chk("t1_rst_cycles", rst_n, 2);
        chk("t1_start_cycles", st_n, 10);
        chk("t1_latency", n, 12);
        chk("t1_rsp1_quiet", bad, 0);
        chk("t1_rsp0_c", rsp0_c, 26);
        chk("t1_rsp0_err", rsp0_err, 0);
        chk("t1_core_rst_resp", core_rst, 1);
        chk("t1_core_start_resp", core_start, 0);
        tick();
        chk("t1_rsp0_hold", rsp0_valid, 1);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        chk("t1_rsp0_consumed", rsp0_valid, 0);
        chk("t1_idle", busy, 0);

        // Simultaneous requests from reset: port 0 first, then port 1, then port 0 again
        resetn = 1'b0;
        #1;
        resetn = 1'b1;
        lat = 4; core_c = 100;
        req0_valid = 1'b1; req0_m = 7;
        req1_valid = 1'b1; req1_m = 9;
        #1;
        chk("t2_req0_ready", req0_ready, 1);
        chk("t2_req1_ready", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        chk("t2_owner0", owner, 0);
        chk("t2_core_m0", core_m, 7);
        chk("t2_req1_wait", req1_ready, 0);
        wait_rsp(0, "t2_rsp0_timeout", n);
        chk("t2_rsp0_c", rsp0_c, 100);
        chk("t2_rsp1_quiet", rsp1_valid, 0);
        core_c = 200;
        rsp0_ready = 1'b1;
        #1;
        chk("t2_req1_resp_state", req1_ready, 0);
        tick();
        rsp0_ready = 1'b0;
        chk("t2_req1_ready", req1_ready, 1);
        chk("t2_rsp0_done", rsp0_valid, 0);
        tick();
        req1_valid = 1'b0;
        chk("t2_owner1", owner, 1);
        chk("t2_core_m1", core_m, 9);
        wait_rsp(1, "t2_rsp1_timeout", n);
        chk("t2_rsp1_c", rsp1_c, 200);
        chk("t2_rsp1_err", rsp1_err, 0);
        chk("t2_rsp0_quiet", rsp0_valid, 0);

        // Backpressure on port 1 with both requesters waiting
        req0_valid = 1'b1; req0_m = 11;
        req1_valid = 1'b1; req1_m = 13;
        core_c = 300;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp1_valid !== 1'b1 || rsp1_c !== 200 || rsp1_err !== 1'b0) bad = 1;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) bad = 1;
            tick();
        end
        chk("t3_stable", bad, 0);
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
        chk("t3_rsp1_consumed", rsp1_valid, 0);
        chk("t3_alt_req0_ready", req0_ready, 1);
        chk("t3_alt_req1_ready", req1_ready, 0);

        // Timeout on port 0 (core never completes)
        model_en = 1'b0;
        tick();
        req0_valid = 1'b0;
        chk("t4_core_m", core_m, 11);
        chk("t4_owner", owner, 0);
        wait_rsp(0, "t4_rsp0_timeout", n);
        chk("t4_latency", n, 18);
        chk("t4_rsp0_c", rsp0_c, 0);
        chk("t4_rsp0_err", rsp0_err, 1);
        chk("t4_timeout_count", timeout_count, 1);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;

        // Following job on port 1 completes normally
        model_en = 1'b1; lat = 3; core_c = 55;
        chk("t4_req1_ready", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        chk("t4_core_m1", core_m, 13);
        wait_rsp(1, "t4_rsp1_timeout", n);
        chk("t4_latency_ok", n, 5);
        chk("t4_rsp1_c", rsp1_c, 55);
        chk("t4_rsp1_err", rsp1_err, 0);
        chk("t4_timeout_count_keep", timeout_count, 1);
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;

        // Stale done stuck high: ignored in the first RUN cycle
        done_force = 1'b1; core_c = 77;
        req0_valid = 1'b1; req0_m = 21;
        #1;
        chk("t5_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        n = 0;
        while (!core_start && n < 10) begin
            tick();
            n++;
        end
        chk("t5_run_reached", n, 2);
        chk("t5_run1_no_rsp", rsp0_valid, 0);
        tick();
        chk("t5_run2_no_rsp", rsp0_valid, 0);
        chk("t5_run2_start", core_start, 1);
        core_c = 88;
        tick();
        chk("t5_rsp0_valid", rsp0_valid, 1);
        chk("t5_rsp0_c", rsp0_c, 88);
        chk("t5_rsp0_err", rsp0_err, 0);
        done_force = 1'b0;
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;

        // Asynchronous reset during RUN
        lat = 10; core_c = 123;
        req1_valid = 1'b1; req1_m = 31;
        tick();
        req1_valid = 1'b0;
        n = 0;
        while (!core_start && n < 10) begin
            tick();
            n++;
        end
        tick();
        tick();
        chk("t6_in_run", core_start, 1);
        resetn = 1'b0;
        #1;
        chk("t6_core_rst", core_rst, 1);
        chk("t6_core_start", core_start, 0);
        chk("t6_busy", busy, 0);
        chk("t6_owner", owner, 0);
        chk("t6_core_m", core_m, 0);
        chk("t6_rsp1_valid", rsp1_valid, 0);
        chk("t6_timeout_count", timeout_count, 0);
        tick();
        resetn = 1'b1;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0) bad = 1;
            tick();
        end
        chk("t6_silent", bad, 0);

        // Normal service after the reset
        lat = 2; core_c = 42;
        req0_valid = 1'b1; req0_m = 41;
        #1;
        chk("t6_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        chk("t6_core_m_new", core_m, 41);
        wait_rsp(0, "t6_rsp0_timeout", n);
        chk("t6_latency", n, 4);
        chk("t6_rsp0_c", rsp0_c, 42);
        chk("t6_rsp0_err", rsp0_err, 0);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        chk("t6_final_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rsa_job_arbiter.md
Name: rsa_job_arbiter

Overview:
- Shares one RSA modexp core between two requesters: port 0 (CPU-side AXI register front end) and port 1 (DMA/secondary master).
- Accepts one job at a time under round-robin arbitration and latches its operands.
- Resets, starts and monitors the core, captures C and returns it to the owning requester.
- Sits between the requester logic and the `rsa` core instance, replacing direct `ctrl[0]`/`ctrl[1]` drive of the core.

Parameters:
- WIDTH, 32, operand/result width (M, E, N, N_INV, R2_MOD_N, C).
- RST_CYCLES, 2, cycles core_rst is held high before each job (≥1).
- TIMEOUT_CYCLES, 4096, maximum cycles in RUN before the job is aborted (≥2).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  job request
- req0_ready / req1_ready  out  1  job accepted this cycle
- req0_m, req0_e, req0_n, req0_ninv, req0_r2  in  WIDTH each  port-0 operands
- req1_m, req1_e, req1_n, req1_ninv, req1_r2  in  WIDTH each  port-1 operands
- rsp0_valid / rsp1_valid  out  1  result available
- rsp0_ready / rsp1_ready  in  1  result consumed
- rsp0_c / rsp1_c  out  WIDTH  result
- rsp0_err / rsp1_err  out  1  job timed out; C forced 0
- core_rst  out  1  active-high synchronous reset to core
- core_start  out  1  core start level
- core_m, core_e, core_n, core_ninv, core_r2  out  WIDTH each  latched operands
- core_c  in  WIDTH  core result
- core_done  in  1  core done level
- busy  out  1  state != IDLE
- owner  out  1  port currently served
- timeout_count  out  8  saturating count of aborted jobs

Behaviour:
- Reset (resetn=0, async) values:
  - state=IDLE, all rsp*_valid=0, rsp*_err=0, rsp*_c=0.
  - core_rst=1, core_start=0, core operands=0.
  - busy=0, owner=0, timeout_count=0.
  - last_grant=1, so port 0 wins first.
- Arbitration: grant = port whose valid is set. If both are set, grant = ~last_grant.
- req*_ready is combinational: (state==IDLE) && valid && grant==port. At most one ready is high per cycle.
- Handshake at IDLE:
  - Latch the winner's operands into core_* regs.
  - owner<=grant, last_grant<=grant.
  - Go to RST with counter=RST_CYCLES-1.
- RST: core_rst=1, core_start=0. Decrement counter; at 0 go to RUN, with the timer cleared on the RST→RUN transition.
- RUN:
  - core_rst=0, core_start=1; timer increments each cycle.
  - core_done is ignored in the first RUN cycle; core state is stale.
  - From the 2nd RUN cycle on, done=1 → capture core_c into rsp[owner]_c, err=0, go to RESP.
  - Else, when timer==TIMEOUT_CYCLES-1 → rsp[owner]_c=0, err=1, timeout_count+1 (saturate at 255), go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - core_start=0, core_rst=1 (idle parking); rsp[owner]_valid=1.
  - On rsp[owner]_valid && rsp[owner]_ready → valid<=0, go to IDLE.
  - Data and err stay stable while valid && !ready.
- core_rst is high in all states except RUN.
- Total latency from req handshake to rsp_valid = RST_CYCLES + N_run + 1 cycles.
- New requests are not accepted until the previous response is consumed; there is no queueing.
- A requester dropping valid before ready has no effect. Its operands are only sampled at handshake.
- Operand changes on req* after handshake do not affect the running job.
- The non-owner's rsp_valid stays 0 throughout.
- Async reset mid-job aborts the job silently: no response, state=IDLE, core held in reset.

Test Plan:
- Single job, port 0: M=5, E=3, N=33, core model done after 10 RUN cycles, C=26 → req0_ready pulse, core_rst high 2 cycles, core_start 10 cycles, rsp0_valid with rsp0_c=26, err=0; rsp1_valid stays 0.
- Simultaneous requests: req0 and req1 valid from reset → port 0 served first; port 1 accepted in the IDLE cycle after rsp0 handshake; a third simultaneous pair grants port 0 again (alternation).
- Response backpressure: rsp1_ready held 0 for 20 cycles → rsp1_valid/rsp1_c stable; req0_valid high throughout gets no ready until the rsp1 handshake.
- Timeout: TIMEOUT_CYCLES=16, core_done never asserts → rsp_valid after 2+16 cycles, c=0, err=1, timeout_count=1; the next job completes normally with err=0.
- Stale done: core_done stuck 1 from the previous job → ignored in RUN cycle 1; capture happens in RUN cycle 2 with core_c sampled then.
- Reset mid-RUN: resetn low for 1 cycle during RUN → all outputs at reset values immediately, no rsp_valid afterwards, busy=0; the next request is served normally.
